// File: rtl/tmds_decoder_if.sv
// Signal bundle between a channel deserializer and its TMDS decoder.
// The deserializer side drives RAW; the decoder drives everything else.
interface tmds_decoder_if;
    logic [9:0] RAW;
    logic [7:0] DATA;
    logic [1:0] C;
    logic       DE;
    logic       LOCKED;
    logic [3:0] OFFSET;

    modport master (output RAW, input DATA, C, DE, LOCKED, OFFSET);
    modport slave  (input RAW, output DATA, C, DE, LOCKED, OFFSET);
endinterface

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder: finds the 10-bit symbol boundary from
// control-token runs during blanking, then decodes aligned symbols.
module tmds_decoder #(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 4096
) (
    input  logic          PCK,
    input  logic          RST,
    tmds_decoder_if.slave bus
);

    typedef enum logic {S_SEARCH = 1'b0, S_LOCK = 1'b1} state_t;

    localparam logic [7:0]  RUN_MAX  = 8'(CTRL_RUN);
    localparam logic [7:0]  RUN_LAST = 8'(CTRL_RUN - 1);
    localparam logic [15:0] WIN_LAST = 16'(SEARCH_WIN - 1);

    state_t      state_q, state_d;
    logic [9:0]  r0_q, r0_d, r1_q, r1_d, a_q, a_d;
    logic [7:0]  run_q, run_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  off_q, off_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  c_q, c_d;
    logic        de_q, de_d;

    logic        tok;
    logic [1:0]  tok_code;
    logic [7:0]  d_raw, dec_byte;
    logic [3:0]  off_next;
    logic        run_hit, win_hit;

    // Token match and TMDS data decode of the registered aligned word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tok      = 1'b0;
        tok_code = 2'b00;
        dec_byte = 8'h00;
        case (a_q)
            10'h354: begin tok = 1'b1; tok_code = 2'b00; end
            10'h0AB: begin tok = 1'b1; tok_code = 2'b01; end
            10'h154: begin tok = 1'b1; tok_code = 2'b10; end
            10'h2AB: begin tok = 1'b1; tok_code = 2'b11; end
            default: ;
        endcase
        d_raw       = a_q[9] ? ~a_q[7:0] : a_q[7:0];
        dec_byte[0] = d_raw[0];
        for (int i = 1; i < 8; i++) begin
            dec_byte[i] = a_q[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
        end
    end

    // Alignment FSM, counters and output formation.
    always_comb begin
        r0_d     = bus.RAW;
        r1_d     = r0_q;
        // The older word sits in the low half so bit order stays continuous across the seam.
        a_d      = 10'({r0_q, r1_q} >> off_q);
        off_next = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
        run_hit  = tok && (run_q >= RUN_LAST);
        win_hit  = (cnt_q == WIN_LAST);

        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        data_d  = 8'h00;
        c_d     = 2'b00;
        de_d    = 1'b0;

        case (state_q)
            S_SEARCH: begin
                if (run_hit) begin
                    state_d = S_LOCK;
                    run_d   = 8'd0;
                    cnt_d   = 16'd0;
                end else if (win_hit) begin
                    off_d = off_next;
                    run_d = 8'd0;
                    cnt_d = 16'd0;
                end else begin
                    run_d = !tok ? 8'd0 : (run_q == RUN_MAX) ? run_q : run_q + 8'd1;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOCK: begin
                if (tok) begin
                    cnt_d = 16'd0;
                    c_d   = tok_code;
                end else if (win_hit) begin
                    state_d = S_SEARCH;
                    off_d   = off_next;
                    run_d   = 8'd0;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                    de_d   = 1'b1;
                    data_d = dec_byte;
                    c_d    = c_q;
                end
            end
        endcase
    end

    always_ff @(posedge PCK or negedge RST) begin
        if (!RST) begin
            state_q <= S_SEARCH;
            r0_q    <= '0;
            r1_q    <= '0;
            a_q     <= '0;
            run_q   <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            data_q  <= '0;
            c_q     <= '0;
            de_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            a_q     <= a_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            data_q  <= data_d;
            c_q     <= c_d;
            de_q    <= de_d;
        end
    end

    assign bus.DATA   = data_q;
    assign bus.C      = c_q;
    assign bus.DE     = de_q;
    assign bus.LOCKED = (state_q == S_LOCK);
    assign bus.OFFSET = off_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: a bit-stream generator feeds the DUT and a
// cycle model built on a TMDS-encoder-derived decode table predicts every output.
module tb_tmds_decoder;

    localparam int CTRL_RUN   = 8;
    localparam int SEARCH_WIN = 64;

    logic PCK = 1'b0;
    logic RST = 1'b0;

    tmds_decoder_if bus ();

    tmds_decoder #(.CTRL_RUN(CTRL_RUN), .SEARCH_WIN(SEARCH_WIN)) dut (
        .PCK(PCK),
        .RST(RST),
        .bus(bus)
    );

    always #5 PCK = ~PCK;

    int vectors     = 0;
    int miscompares = 0;
    int rst_cyc     = 0;
    int disparity   = 0;

    logic [7:0] dec_tab [1024];
    logic [7:0] sb_q[$];
    bit         bitq[$];

    // Reference model state: word history, aligned symbol, lock status, counters.
    int m_last, m_prev, m_a, m_off, m_run, m_cnt, m_data, m_c;
    bit m_lock, m_de;

    function automatic logic [8:0] qm_of(input logic [7:0] b, input bit use_xnor);
        logic [8:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // DVI transmit encoder with running disparity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] b);
        int         n1, ones, diff;
        bit         use_xnor;
        logic [8:0] q;
        logic [9:0] s;
        n1       = $countones(b);
        use_xnor = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
        q        = qm_of(b, use_xnor);
        ones     = $countones(q[7:0]);
        diff     = ones - (8 - ones);
        if (disparity == 0 || diff == 0) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            disparity += q[8] ? diff : -diff;
        end else if ((disparity > 0 && diff > 0) || (disparity < 0 && diff < 0)) begin
            s = {1'b1, q[8], ~q[7:0]};
            disparity += (q[8] ? 2 : 0) - diff;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            disparity += diff - (q[8] ? 0 : 2);
        end
        return s;
    endfunction

    // Every 10-bit code is some byte encoded in one of two chain modes, inverted or not.
    task automatic build_table();
        logic [8:0] q;
        for (int b = 0; b < 256; b++) begin
            for (int m = 0; m < 2; m++) begin
                q = qm_of(8'(b), m == 1);
                dec_tab[{1'b0, q}]               = 8'(b);
                dec_tab[{1'b1, q[8], ~q[7:0]}]   = 8'(b);
            end
        end
    endtask

    function automatic int token_code(input int a);
        case (a)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_edge(input int w);
        int a_new, code, c_prev;
        a_new  = ((m_last * 1024 + m_prev) >> m_off) & 1023;
        code   = token_code(m_a);
        c_prev = m_c;
        m_de   = 1'b0;
        m_data = 0;
        m_c    = 0;
        if (!m_lock) begin
            if (code >= 0 && m_run + 1 >= CTRL_RUN) begin
                m_lock = 1'b1; m_run = 0; m_cnt = 0;
            end else if (m_cnt == SEARCH_WIN - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_cnt = 0;
            end else begin
                m_run = (code >= 0) ? m_run + 1 : 0;
                m_cnt++;
            end
        end else if (code >= 0) begin
            m_cnt = 0;
            m_c   = code;
        end else if (m_cnt == SEARCH_WIN - 1) begin
            m_lock = 1'b0; m_off = (m_off + 1) % 10; m_cnt = 0; m_run = 0;
        end else begin
            m_cnt++;
            m_de   = 1'b1;
            m_data = dec_tab[m_a];
            m_c    = c_prev;
        end
        m_prev = m_last;
        m_last = w;
        m_a    = a_new;
    endtask

    function automatic logic [15:0] dut_vec();
        return {bus.DATA, bus.C, bus.DE, bus.LOCKED, bus.OFFSET};
    endfunction

    function automatic logic [15:0] model_vec();
        return {8'(m_data), 2'(m_c), m_de, m_lock, 4'(m_off)};
    endfunction

    task automatic step(input logic [9:0] w);
        bus.RAW = w;
        @(posedge PCK);
        model_edge(int'(w));
        rst_cyc++;
        #1;
    endtask

    // Symbols go into a bit stream (bit 0 first); each symbol pushed yields one word.
    task automatic send_sym(input logic [9:0] sym);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bitq.push_back(sym[i]);
        w = '0;
        for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
        step(w);
    endtask

    task automatic apply_reset(input int delay_bits);
        RST     = 1'b0;
        bus.RAW = '0;
        repeat (2) @(posedge PCK);
        #1;
        m_last = 0; m_prev = 0; m_a = 0; m_off = 0; m_run = 0; m_cnt = 0;
        m_data = 0; m_c = 0; m_lock = 1'b0; m_de = 1'b0;
        rst_cyc   = 0;
        disparity = 0;
        bitq.delete();
        for (int i = 0; i < delay_bits; i++) bitq.push_back(1'b0);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.RAW = 10'($urandom);
            @(posedge PCK);
            #1;
            vectors++;
            if (dut_vec() !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_hold %0d: got %h expected 0000", i, dut_vec());
            end
        end
        apply_reset(0);
    endtask

    task automatic test_lock_aligned();
        apply_reset(0);
        for (int i = 0; i < 24; i++) begin
            send_sym(i < 20 ? 10'h354 : 10'h100);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL lock_aligned cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (i == 19) begin
                vectors++;
                if ({bus.LOCKED, bus.OFFSET, bus.C, bus.DE} !== {1'b1, 4'd0, 2'b00, 1'b0}) begin
                    miscompares++;
                    $display("FAIL lock_aligned_state: got L=%b O=%0d C=%b DE=%b expected L=1 O=0 C=00 DE=0",
                             bus.LOCKED, bus.OFFSET, bus.C, bus.DE);
                end
            end
        end
        vectors++;
        if ({bus.DE, bus.DATA} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL lock_aligned_data: got DE=%b DATA=%h expected DE=1 DATA=00", bus.DE, bus.DATA);
        end
        for (int i = 0; i < 4; i++) begin
            send_sym(10'h354);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL lock_flush cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_decode_beat(input logic [9:0] sym);
        logic [7:0] exp_b;
        send_sym(sym);
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL decode_cycle sym %h: got %h expected %h", sym, dut_vec(), model_vec());
        end
        if (bus.DE === 1'b1) begin
            exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            vectors++;
            if (bus.DATA !== exp_b) begin
                miscompares++;
                $display("FAIL decode_byte: got %h expected %h", bus.DATA, exp_b);
            end
        end
    endtask

    task automatic test_decode();
        logic [7:0] b;
        sb_q.delete();
        sb_q.push_back(8'hFE);
        test_decode_beat(10'h2FF);
        sb_q.push_back(8'h00);
        test_decode_beat(10'h100);
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            sb_q.push_back(b);
            test_decode_beat(tmds_encode(b));
            if (i % 24 == 23) test_decode_beat(10'h354);
        end
        for (int i = 0; i < 4; i++) test_decode_beat(10'h0AB);
        vectors++;
        if ({bus.DE, bus.C, sb_q.size() == 0} !== {1'b0, 2'b01, 1'b1}) begin
            miscompares++;
            $display("FAIL decode_tail: got DE=%b C=%b left=%0d expected DE=0 C=01 left=0",
                     bus.DE, bus.C, sb_q.size());
        end
    endtask

    task automatic test_loss();
        for (int i = 0; i < SEARCH_WIN + 5; i++) begin
            send_sym(10'h100);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL loss cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if ({bus.LOCKED, bus.OFFSET, bus.DE, bus.C} !== {1'b0, 4'd1, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL loss_state: got L=%b O=%0d DE=%b C=%b expected L=0 O=1 DE=0 C=00",
                     bus.LOCKED, bus.OFFSET, bus.DE, bus.C);
        end
    endtask

    task automatic test_wrap();
        int seen[$];
        int prev_off;
        apply_reset(0);
        prev_off = 0;
        for (int i = 0; i < 10 * SEARCH_WIN + 5; i++) begin
            send_sym(10'h100);
            vectors++;
            if (dut_vec() !== model_vec() || bus.LOCKED !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (int'(bus.OFFSET) != prev_off) begin
                prev_off = int'(bus.OFFSET);
                seen.push_back(prev_off);
            end
        end
        vectors++;
        if (seen.size() != 10) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d offset changes expected 10", seen.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (seen[i] != (i + 1) % 10) begin
                    miscompares++;
                    $display("FAIL wrap_seq[%0d]: got %0d expected %0d", i, seen[i], (i + 1) % 10);
                end
            end
        end
    endtask

    task automatic test_shifted();
        int change_at[$];
        int prev_off;
        apply_reset(3);
        prev_off = 0;
        for (int i = 0; i < 3 * SEARCH_WIN + 40; i++) begin
            send_sym(10'h2AB);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL shifted cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            if (int'(bus.OFFSET) != prev_off) begin
                prev_off = int'(bus.OFFSET);
                change_at.push_back(rst_cyc);
            end
        end
        vectors++;
        if (change_at.size() != 3 || change_at[0] != SEARCH_WIN || change_at[1] != 2 * SEARCH_WIN
            || change_at[2] != 3 * SEARCH_WIN) begin
            miscompares++;
            $display("FAIL shifted_steps: got %p expected {%0d, %0d, %0d}", change_at,
                     SEARCH_WIN, 2 * SEARCH_WIN, 3 * SEARCH_WIN);
        end
        vectors++;
        if ({bus.LOCKED, bus.OFFSET, bus.C} !== {1'b1, 4'd3, 2'b11}) begin
            miscompares++;
            $display("FAIL shifted_lock: got L=%b O=%0d C=%b expected L=1 O=3 C=11",
                     bus.LOCKED, bus.OFFSET, bus.C);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(0);
        for (int i = 0; i < 24; i++) send_sym(i < 20 ? 10'h354 : 10'h100);
        vectors++;
        if ({bus.LOCKED, bus.DE} !== 2'b11 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got %h expected %h with L=1 DE=1", dut_vec(), model_vec());
        end
        bus.RAW = 10'h100;
        #3;
        RST = 1'b0;
        #1;
        vectors++;
        if (dut_vec() !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %h expected 0000", dut_vec());
        end
        apply_reset(0);
        for (int i = 0; i < 20; i++) begin
            send_sym(10'h354);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL relock cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (bus.LOCKED !== 1'b1) begin
            miscompares++;
            $display("FAIL relock_state: got LOCKED=%b expected 1", bus.LOCKED);
        end
    endtask

    task automatic test_back_to_back();
        int                  n;
        logic [9:0]          sym;
        logic [9:0]          toks [4];
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
        apply_reset(int'($urandom_range(0, 9)));
        n = 0;
        while (n < 2000) begin
            bit tok_burst;
            int len;
            tok_burst = ($urandom_range(0, 2) == 0);
            len       = tok_burst ? int'($urandom_range(6, 14)) : int'($urandom_range(5, 50));
            for (int i = 0; i < len; i++) begin
                if (tok_burst) sym = toks[$urandom_range(0, 3)];
                else if ($urandom_range(0, 9) == 0) sym = 10'($urandom);
                else sym = tmds_encode(8'($urandom));
                send_sym(sym);
                n++;
                vectors++;
                if (dut_vec() !== model_vec()) begin
                    miscompares++;
                    $display("FAIL back_to_back cyc %0d: got %h expected %h", n, dut_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        bus.RAW = '0;
        build_table();
        test_reset();
        test_lock_aligned();
        test_decode();
        test_loss();
        test_wrap();
        test_shifted();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
